// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl
// Request-side controller in front of a single-port block RAM with a 1-cycle
// registered read. Converts a valid/ready byte-addressed request stream into
// word accesses, returns a one-cycle response pulse, flags out-of-range
// accesses and zero-fills the whole RAM after every reset.
//
// Ports
//   i_clk             clock
//   i_rst_n           asynchronous active-low reset
//   i_req_valid       request present
//   o_req_ready       request can be accepted this cycle
//   i_req_write       1 = write, 0 = read
//   i_req_addr        byte address, bits [1:0] ignored
//   i_req_wdata       write data
//   o_resp_valid      one-cycle response pulse
//   o_resp_data       read data (0 for writes and errors)
//   o_resp_err        out-of-range access, qualified by o_resp_valid
//   o_busy            high while clearing or waiting on a read
//   o_ram_address     RAM word address
//   o_ram_write_data  RAM write data
//   o_ram_write_en    RAM write enable
//   i_ram_read_data   RAM read data
//
// state   | meaning
// --------+--------------------------------------------------------
// CLEAR   | zero-fill RAM, one word per cycle, DEPTH cycles total
// IDLE    | accept requests; writes and errors respond next cycle
// RD_WAIT | RAM read in flight; capture read data into response
module ram_req_ctrl #(
  parameter  int SIZE   = 32,
  parameter  int DEPTH  = 256,
  parameter  int ADDR_W = 32,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [SIZE-1:0]   i_req_wdata,
  output logic              o_resp_valid,
  output logic [SIZE-1:0]   o_resp_data,
  output logic              o_resp_err,
  output logic              o_busy,
  output logic [AW-1:0]     o_ram_address,
  output logic [SIZE-1:0]   o_ram_write_data,
  output logic              o_ram_write_en,
  input  logic [SIZE-1:0]   i_ram_read_data
);

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    IDLE    = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  localparam logic [63:0] DEPTH_W = 64'(DEPTH);

  state_t          r_state;
  logic [AW-1:0]   r_clr_cnt;
  logic [AW-1:0]   r_rd_addr;

  logic [ADDR_W-3:0] w_idx;
  logic              w_in_range;
  logic              w_accept;
  logic              w_ram_we;

  assign w_idx      = i_req_addr[ADDR_W-1:2];
  // Full-width compare so high address bits can never alias into the RAM.
  assign w_in_range = (64'(w_idx) < DEPTH_W);
  assign w_accept   = i_req_valid & o_req_ready;

  assign o_req_ready = (r_state == IDLE);
  assign o_busy      = (r_state != IDLE);

  always_comb begin
    o_ram_address    = '0;
    o_ram_write_data = '0;
    w_ram_we         = 1'b0;
    case (r_state)
      CLEAR: begin
        o_ram_address = r_clr_cnt;
        w_ram_we      = 1'b1;
      end
      IDLE: begin
        if (w_accept && w_in_range) begin
          o_ram_address = w_idx[AW-1:0];
          if (i_req_write) begin
            o_ram_write_data = i_req_wdata;
            w_ram_we         = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        o_ram_address = r_rd_addr;
      end
      default: begin
        o_ram_address = '0;
      end
    endcase
  end

  // The state is already CLEAR during reset; gating keeps the RAM from being
  // written while reset is asserted.
  assign o_ram_write_en = w_ram_we & i_rst_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= CLEAR;
      r_clr_cnt    <= '0;
      r_rd_addr    <= '0;
      o_resp_valid <= 1'b0;
      o_resp_data  <= '0;
      o_resp_err   <= 1'b0;
    end else begin
      o_resp_valid <= 1'b0;
      case (r_state)
        CLEAR: begin
          if (r_clr_cnt == AW'(DEPTH - 1)) begin
            r_clr_cnt <= '0;
            r_state   <= IDLE;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (w_accept) begin
            if (!w_in_range) begin
              o_resp_valid <= 1'b1;
              o_resp_err   <= 1'b1;
              o_resp_data  <= '0;
            end else if (i_req_write) begin
              o_resp_valid <= 1'b1;
              o_resp_err   <= 1'b0;
              o_resp_data  <= '0;
            end else begin
              r_rd_addr <= w_idx[AW-1:0];
              r_state   <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          o_resp_valid <= 1'b1;
          o_resp_err   <= 1'b0;
          o_resp_data  <= i_ram_read_data;
          r_state      <= IDLE;
        end
        default: begin
          r_state <= CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_req_ctrl.sv
module tb_ram_req_ctrl;

  localparam int SIZE   = 32;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 32;
  localparam int AW     = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [SIZE-1:0]   req_wdata;
  logic              resp_valid;
  logic [SIZE-1:0]   resp_data;
  logic              resp_err;
  logic              busy;
  logic [AW-1:0]     ram_address;
  logic [SIZE-1:0]   ram_write_data;
  logic              ram_write_en;
  logic [SIZE-1:0]   ram_read_data;

  int checks   = 0;
  int failures = 0;

  logic [SIZE-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  ram_req_ctrl #(.SIZE(SIZE), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_req_valid      (req_valid),
    .o_req_ready      (req_ready),
    .i_req_write      (req_write),
    .i_req_addr       (req_addr),
    .i_req_wdata      (req_wdata),
    .o_resp_valid     (resp_valid),
    .o_resp_data      (resp_data),
    .o_resp_err       (resp_err),
    .o_busy           (busy),
    .o_ram_address    (ram_address),
    .o_ram_write_data (ram_write_data),
    .o_ram_write_en   (ram_write_en),
    .i_ram_read_data  (ram_read_data)
  );

  // Single-port RAM, read-first, 1-cycle registered read.
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_address] <= ram_write_data;
    ram_read_data <= mem[ram_address];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    #1;
  endtask

  task automatic idle_in();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  // Called right after reset release; walks the full clear sequence.
  task automatic run_clear(input string tag);
    int nz;
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      chk(tag, 64'({resp_valid, req_ready, busy, ram_write_en, ram_address, ram_write_data}),
          64'({1'b0, 1'b0, 1'b1, 1'b1, 8'(k), 32'h0}));
      if (k == DEPTH - 1) idle_in();
      tick();
    end
    chk({tag, "_ready_after"}, 64'({req_ready, busy}), 64'({1'b1, 1'b0}));
    nz = 0;
    for (int k = 0; k < DEPTH; k++) if (mem[k] != '0) nz++;
    chk({tag, "_ram_zeroed"}, 64'(nz), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = $urandom | 32'h1;
    rst_n = 1'b0;
    idle_in();
    #2;
    chk("reset_state", 64'({req_ready, busy, ram_write_en, resp_valid, resp_err, resp_data}),
        64'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0}));
    tick();
    tick();
    rst_n = 1'b1;
    run_clear("clear1");

    // Write 0xDEADBEEF to 0x10 (word 4)
    drive(1'b1, 32'h10, 32'hDEAD_BEEF);
    chk("wr_accept_ram", 64'({ram_write_en, ram_address, ram_write_data}),
        64'({1'b1, 8'd4, 32'hDEAD_BEEF}));
    tick();
    idle_in();
    chk("wr_resp", 64'({resp_valid, resp_err, resp_data}), 64'({1'b1, 1'b0, 32'h0}));

    // Read 0x13 -> same word, 2-cycle latency
    drive(1'b0, 32'h13, 32'h0);
    chk("rd_accept_ram", 64'({ram_write_en, ram_address}), 64'({1'b0, 8'd4}));
    tick();
    idle_in();
    #1;
    chk("rd_wait", 64'({resp_valid, req_ready, busy, ram_write_en, ram_address}),
        64'({1'b0, 1'b0, 1'b1, 1'b0, 8'd4}));
    tick();
    chk("rd_resp", 64'({resp_valid, resp_err, resp_data, req_ready}),
        64'({1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1}));
    tick();
    chk("rd_resp_hold", 64'({resp_valid, resp_data}), 64'({1'b0, 32'hDEAD_BEEF}));

    // Read top in-range word 0x3FC (cleared)
    drive(1'b0, 32'h3FC, 32'h0);
    chk("rd_top_addr", 64'({ram_write_en, ram_address}), 64'({1'b0, 8'd255}));
    tick();
    idle_in();
    tick();
    chk("rd_top_resp", 64'({resp_valid, resp_err, resp_data}), 64'({1'b1, 1'b0, 32'h0}));
    tick();

    // Out-of-range write 0x400 (idx 256)
    drive(1'b1, 32'h400, 32'h1234);
    chk("oor_wr_no_we", 64'(ram_write_en), 64'(0));
    tick();
    idle_in();
    chk("oor_wr_resp", 64'({resp_valid, resp_err, resp_data, req_ready}),
        64'({1'b1, 1'b1, 32'h0, 1'b1}));
    drive(1'b0, 32'h0, 32'h0);
    tick();
    idle_in();
    chk("after_oor_rd_pending", 64'({resp_valid, busy}), 64'({1'b0, 1'b1}));
    tick();
    chk("rd0_resp", 64'({resp_valid, resp_err, resp_data}), 64'({1'b1, 1'b0, 32'h0}));

    // Out-of-range read at the top of the address space
    drive(1'b0, 32'hFFFF_FFFC, 32'h0);
    chk("oor_rd_no_we", 64'(ram_write_en), 64'(0));
    tick();
    idle_in();
    chk("oor_rd_resp", 64'({resp_valid, resp_err, resp_data, req_ready}),
        64'({1'b1, 1'b1, 32'h0, 1'b1}));

    // Back-to-back writes, then read-after-write of the same word
    drive(1'b1, 32'h24, 32'hA5A5_0001);
    tick();
    chk("b2b_wr1_resp", 64'({resp_valid, resp_err}), 64'({1'b1, 1'b0}));
    drive(1'b1, 32'h20, 32'h0000_0001);
    chk("b2b_wr2_ram", 64'({ram_write_en, ram_address}), 64'({1'b1, 8'd8}));
    tick();
    chk("b2b_wr2_resp", 64'({resp_valid, resp_err}), 64'({1'b1, 1'b0}));
    drive(1'b0, 32'h20, 32'h0);
    chk("raw_rd_addr", 64'({ram_write_en, ram_address}), 64'({1'b0, 8'd8}));
    tick();
    idle_in();
    tick();
    chk("raw_rd_resp", 64'({resp_valid, resp_data}), 64'({1'b1, 32'h0000_0001}));
    // New request accepted in the response cycle
    drive(1'b0, 32'h24, 32'h0);
    chk("c2_accept", 64'({req_ready, ram_address}), 64'({1'b1, 8'd9}));
    tick();
    idle_in();
    tick();
    chk("c2_rd_resp", 64'({resp_valid, resp_data}), 64'({1'b1, 32'hA5A5_0001}));
    tick();

    // Reset during RD_WAIT drops the response and re-clears the RAM
    drive(1'b0, 32'h10, 32'h0);
    tick();
    idle_in();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", 64'({resp_valid, ram_write_en, req_ready, busy, resp_data}),
        64'({1'b0, 1'b0, 1'b0, 1'b1, 32'h0}));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_mid_no_resp", 64'({resp_valid, ram_write_en}), 64'({1'b0, 1'b0}));
    end
    rst_n = 1'b1;
    // Requests presented during CLEAR must be ignored
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h10;
    req_wdata = 32'hFFFF_FFFF;
    run_clear("clear2");

    drive(1'b0, 32'h10, 32'h0);
    tick();
    idle_in();
    tick();
    chk("rd_after_reclear", 64'({resp_valid, resp_err, resp_data}), 64'({1'b1, 1'b0, 32'h0}));
    tick();
    chk("resp_pulse_end", 64'(resp_valid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
